lms_sample_scheduler: RTL and testbench

- Sequences one LMS adaptive-filter datapath at the audio sample rate.
- Accepts (x, d) sample pairs over a valid/ready handshake and presents them to the filter. Strobes one compute cycle per sample, then captures filter output and error after a fixed latency.
- Runs a two-gear step-size schedule: fast convergence first, then slow tracking. Adaptation can be frozen on request.
- Watches the error for divergence, and on divergence clears the coefficients and restarts the schedule.
- Sits between the sample source (file/ADC feeder) and the lms datapath.

---
 rtl/lms_sample_scheduler_if.sv | 9 +
 rtl/lms_sample_scheduler.sv | 110 +++++++++++
 tb/tb_lms_sample_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lms_sample_scheduler_if.sv
// lms_sample_scheduler_if: valid/ready handshake carrying (x, d) sample pairs
interface lms_sample_scheduler_if #(parameter int W = 16);
  logic in_valid;
  logic in_ready;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] d_in;
  modport master(output in_valid, x_in, d_in, input in_ready);
  modport slave(input in_valid, x_in, d_in, output in_ready);
endinterface

// File: rtl/lms_sample_scheduler.sv
// lms_sample_scheduler: per-sample sequencing, step-size gearing and divergence recovery for an LMS datapath
module lms_sample_scheduler #(
  parameter int W = 16,
  parameter int PERIOD = 8,
  parameter int LAT = 3,
  parameter int U_FAST = 4,
  parameter int U_SLOW = 6,
  parameter int GEAR_LEN = 1024,
  parameter int ERR_LIMIT = 24000,
  parameter int ERR_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  lms_sample_scheduler_if.slave smp,
  input  logic freeze,
  input  logic clr_diverge,
  output logic signed [W-1:0] lms_xin,
  output logic signed [W-1:0] lms_din,
  output logic [3:0] lms_u,
  output logic lms_ce,
  output logic lms_update,
  output logic lms_clr,
  input  logic signed [W-1:0] lms_yout,
  input  logic signed [W-1:0] lms_err,
  output logic out_valid,
  output logic signed [W-1:0] out_y,
  output logic signed [W-1:0] out_err,
  output logic diverge,
  output logic gear
);
  localparam int SW = $clog2(PERIOD + 1);
  localparam int CW = $clog2(GEAR_LEN + 1);
  localparam int RW = $clog2(ERR_RUN + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPT, HOLD} st_t;
  st_t r_st, w_nxt;
  logic [SW-1:0] r_slot;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_run;
  logic [RW-1:0] w_run1;
  logic [3:0] r_u;
  logic r_clr_pend, r_div;
  logic signed [W-1:0] r_xin, r_din, r_y, r_err, w_abs;
  logic w_acc, w_over, w_trip;
  assign smp.in_ready = (r_st == IDLE) && !r_clr_pend;
  assign lms_clr = (r_st == IDLE) && r_clr_pend;
  assign lms_ce = (r_st == LOAD);
  assign lms_update = (r_st == LOAD) && !freeze;
  assign out_valid = (r_st == HOLD) && (r_slot == SW'(LAT + 2));
  assign lms_xin = r_xin;
  assign lms_din = r_din;
  assign lms_u = r_u;
  assign out_y = r_y;
  assign out_err = r_err;
  assign diverge = r_div;
  assign gear = (r_cnt == CW'(GEAR_LEN));
  assign w_acc = smp.in_valid && smp.in_ready;
  // the most negative code has no positive twin, so it clamps to the largest positive value
  assign w_abs = (lms_err == {1'b1, {(W-1){1'b0}}}) ? {1'b0, {(W-1){1'b1}}} :
                 (lms_err[W-1] ? -lms_err : lms_err);
  assign w_over = int'(w_abs) > ERR_LIMIT;
  assign w_run1 = r_run + 1'b1;
  assign w_trip = w_over && (w_run1 == RW'(ERR_RUN));
  always_ff @(posedge clk)
    if (rst) r_st <= IDLE;
    else r_st <= w_nxt;
  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      IDLE: w_nxt = w_acc ? LOAD : IDLE;
      LOAD: w_nxt = (LAT == 1) ? CAPT : WAIT;
      WAIT: w_nxt = (r_slot == SW'(LAT)) ? CAPT : WAIT;
      CAPT: w_nxt = HOLD;
      HOLD: w_nxt = (r_slot == SW'(PERIOD - 1)) ? IDLE : HOLD;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
      r_cnt <= '0;
      r_run <= '0;
      r_u <= 4'(U_FAST);
      r_clr_pend <= 1'b0;
      r_div <= 1'b0;
      r_xin <= '0;
      r_din <= '0;
      r_y <= '0;
      r_err <= '0;
    end else begin
      if (w_acc) begin
        r_xin <= smp.x_in;
        r_din <= smp.d_in;
        r_u <= gear ? 4'(U_SLOW) : 4'(U_FAST);
      end
      r_slot <= w_acc ? SW'(1) : ((r_st != IDLE) ? r_slot + 1'b1 : r_slot);
      if (lms_clr) r_clr_pend <= 1'b0;
      if (lms_ce && !gear) r_cnt <= r_cnt + 1'b1;
      if (r_st == CAPT) begin
        r_y <= lms_yout;
        r_err <= lms_err;
        r_run <= (w_over && !w_trip) ? w_run1 : '0;
        if (w_trip) begin
          r_cnt <= '0;
          r_clr_pend <= 1'b1;
        end
      end
      r_div <= ((r_st == CAPT) && w_trip) || (r_div && !clr_diverge);
    end
  end
endmodule

// File: tb/tb_lms_sample_scheduler.sv
// tb_lms_sample_scheduler: directed checks of slot timing, gearing, freeze and divergence handling
module tb_lms_sample_scheduler;
  localparam int W = 16;
  localparam int PERIOD = 8;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic freeze = 1'b0;
  logic clr_diverge = 1'b0;
  lms_sample_scheduler_if #(.W(W)) smp();
  logic signed [W-1:0] lms_xin, lms_din, lms_yout, lms_err, out_y, out_err;
  logic [3:0] lms_u;
  logic lms_ce, lms_update, lms_clr, out_valid, diverge, gear;
  logic use_cyc = 1'b0;
  logic [15:0] err_val = '0;
  logic [15:0] y_val = '0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int c0, s_waits, s_clr, s_n_ce, s_n_ov, s_rdy_hi, s_ce_i, s_ov_i;
  logic s_upd, s_gear, s_rdy_end;
  logic [3:0] s_u;
  logic [15:0] s_err, s_y, s_xin, s_din, s_xin_end;
  lms_sample_scheduler #(.W(W), .PERIOD(PERIOD), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .smp(smp), .freeze(freeze), .clr_diverge(clr_diverge),
    .lms_xin(lms_xin), .lms_din(lms_din), .lms_u(lms_u), .lms_ce(lms_ce),
    .lms_update(lms_update), .lms_clr(lms_clr), .lms_yout(lms_yout), .lms_err(lms_err),
    .out_valid(out_valid), .out_y(out_y), .out_err(out_err), .diverge(diverge), .gear(gear)
  );
  assign lms_err = use_cyc ? 16'(cyc) : err_val;
  assign lms_yout = y_val;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // drives one pair from an IDLE negedge and records what the slot did; ends at the negedge of t0+PERIOD
  task automatic run_slot(input logic [15:0] x, d, e, y, input logic clr_at_capt);
    smp.in_valid = 1'b1;
    smp.x_in = x;
    smp.d_in = d;
    err_val = e;
    y_val = y;
    s_waits = 0; s_clr = 0; s_n_ce = 0; s_n_ov = 0; s_rdy_hi = 0; s_ce_i = 0; s_ov_i = 0;
    s_upd = 1'b0; s_gear = 1'b0; s_u = '0;
    while (!smp.in_ready && s_waits < 16) begin
      if (lms_clr) s_clr++;
      @(negedge clk);
      s_waits++;
    end
    if (!smp.in_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    c0 = cyc;
    for (int i = 1; i < PERIOD; i++) begin
      @(negedge clk);
      if (i == 1) begin s_xin = lms_xin; s_din = lms_din; end
      if (i == 2) begin smp.x_in = 16'hDEAD; smp.d_in = 16'hBEEF; end
      if (lms_ce) begin s_n_ce++; s_ce_i = i; s_upd = lms_update; s_u = lms_u; s_gear = gear; end
      if (out_valid) begin s_n_ov++; s_ov_i = i; s_err = out_err; s_y = out_y; end
      if (smp.in_ready) s_rdy_hi++;
      if (lms_clr) s_clr++;
      clr_diverge = clr_at_capt && (i == LAT + 1);
    end
    @(negedge clk);
    s_xin_end = lms_xin;
    s_rdy_end = smp.in_ready;
  endtask
  initial begin
    int prev_c0, bad_u, frz_upd, frz_ov, n, k;
    logic [15:0] pat [5];
    smp.in_valid = 1'b0;
    smp.x_in = '0;
    smp.d_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", smp.in_ready, 1);
    chk("rst_u", lms_u, 4);
    chk("rst_div", diverge, 0);
    chk("rst_gear", gear, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ce", lms_ce, 0);
    chk("rst_clr", lms_clr, 0);
    use_cyc = 1'b1;
    run_slot(16'h0100, 16'h0200, 16'h0, 16'h1234, 1'b0);
    chk("t1_ce_at", s_ce_i, 1);
    chk("t1_n_ce", s_n_ce, 1);
    chk("t1_ov_at", s_ov_i, 5);
    chk("t1_n_ov", s_n_ov, 1);
    chk("t1_xin", s_xin, 16'h0100);
    chk("t1_din", s_din, 16'h0200);
    chk("t1_err", s_err, 16'(c0 + 4));
    chk("t1_y", s_y, 16'h1234);
    chk("t1_ready_low", s_rdy_hi, 0);
    chk("t1_xin_hold", s_xin_end, 16'h0100);
    chk("t1_ready_back", s_rdy_end, 1);
    chk("t1_u", s_u, 4);
    chk("t1_upd", s_upd, 1);
    prev_c0 = c0;
    run_slot(16'h0100, 16'h0200, 16'h0, 16'h1234, 1'b0);
    chk("t1_second_wait", s_waits, 0);
    chk("t1_spacing", c0 - prev_c0, PERIOD);
    use_cyc = 1'b0;
    bad_u = 0; frz_upd = 0; frz_ov = 0;
    for (int s = 3; s <= 1030; s++) begin
      freeze = (s >= 10 && s <= 19);
      run_slot(16'(s), 16'(s + 1), 16'(s), 16'h0, 1'b0);
      if (freeze) begin frz_upd += int'(s_upd); frz_ov += s_n_ov; end
      if (s == 20) chk("frz_resume_upd", s_upd, 1);
      if (s_u != ((s <= 1024) ? 4'd4 : 4'd6) || s_gear != (s > 1024) || s_n_ov != 1) bad_u++;
      if (s == 1024) begin chk("g1024_u", s_u, 4); chk("g1024_gear", s_gear, 0); end
      if (s == 1025) begin chk("g1025_u", s_u, 6); chk("g1025_gear", s_gear, 1); end
    end
    freeze = 1'b0;
    chk("frz_upd_cnt", frz_upd, 0);
    chk("frz_ov_cnt", frz_ov, 10);
    chk("sched_errs", bad_u, 0);
    chk("gear_slow", gear, 1);
    for (int j = 0; j < 4; j++) begin
      run_slot(16'h1, 16'h2, 16'h8000, 16'h0, 1'b0);
      if (j == 2) chk("sat_div_early", diverge, 0);
    end
    chk("sat_div", diverge, 1);
    chk("sat_err", s_err, 16'h8000);
    chk("sat_gear_clr", gear, 0);
    chk("sat_slot_u", s_u, 6);
    run_slot(16'h1, 16'h2, 16'h0, 16'h0, 1'b0);
    chk("sat_clr_pulses", s_clr, 1);
    chk("sat_clr_wait", s_waits, 1);
    chk("sat_u_fast", s_u, 4);
    chk("sat_sticky", diverge, 1);
    smp.in_valid = 1'b0;
    clr_diverge = 1'b1;
    @(negedge clk);
    clr_diverge = 1'b0;
    chk("clr_diverge", diverge, 0);
    repeat (4) run_slot(16'h1, 16'h2, 16'd24000, 16'h0, 1'b0);
    chk("lim_equal", diverge, 0);
    for (int j = 0; j < 4; j++) run_slot(16'h1, 16'h2, 16'(-24001), 16'h0, j == 3);
    chk("lim_over_set_wins", diverge, 1);
    smp.in_valid = 1'b0;
    clr_diverge = 1'b1;
    @(negedge clk);
    clr_diverge = 1'b0;
    pat[0] = 16'd25000; pat[1] = 16'd25000; pat[2] = 16'd25000; pat[3] = 16'd100; pat[4] = 16'd25000;
    for (int j = 0; j < 5; j++) run_slot(16'h1, 16'h2, pat[j], 16'h0, 1'b0);
    chk("pat_no_div", diverge, 0);
    repeat (3) run_slot(16'h1, 16'h2, 16'd25000, 16'h0, 1'b0);
    chk("pat_div", diverge, 1);
    smp.in_valid = 1'b1;
    k = 0;
    while (!smp.in_ready && k < 16) begin @(negedge clk); k++; end
    chk("mid_ready_seen", smp.in_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    smp.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_ready", smp.in_ready, 1);
    chk("mid_div", diverge, 0);
    chk("mid_u", lms_u, 4);
    n = 0;
    repeat (PERIOD) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    chk("mid_no_ov", n, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
